matrix_result_writer: RTL and testbench

//  Downstream sink for matrix operator result streams (add, sub, mul, ...). Accepts one

---
 rtl/matrix_op_defs_pkg.sv | 31 +++
 rtl/matrix_result_writer_if.sv | 33 +++
 rtl/matrix_address_getter.sv | 13 +
 rtl/matrix_result_writer.sv | 189 ++++++++++++++++++
 tb/tb_matrix_result_writer.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/matrix_op_defs_pkg.sv
// Shared definitions for the matrix operator result path: block geometry,
// writer FSM states, shape-word encoding and block capacity check.
package matrix_op_defs_pkg;

  localparam int MATRIX_BLOCK_SIZE     = 256;
  localparam int MATRIX_ADDR_WIDTH     = 12;
  localparam int MATRIX_DATA_WIDTH     = 32;
  localparam int MATRIX_METADATA_WORDS = 3;
  localparam int MATRIX_NAME_BYTES     = 8;

  typedef enum logic [2:0] {
    WR_IDLE,
    WR_META,
    WR_STREAM,
    WR_FILL,
    WR_DONE
  } matrix_writer_state_e;

  // Shape word layout: rows in [15:8], cols in [7:0], upper bits zero.
  function automatic logic [31:0] encode_shape_word(input logic [7:0] rows,
                                                    input logic [7:0] cols);
    return {16'h0000, rows, cols};
  endfunction

  function automatic logic is_data_capacity_ok(input logic [15:0] count,
                                               input int block_size,
                                               input int meta_words);
    return (count != 16'd0) && (int'(count) <= (block_size - meta_words));
  endfunction

endpackage

// File: rtl/matrix_result_writer_if.sv
// Request/stream/status bundle between a matrix operator (master) and the
// result writer (slave).
interface matrix_result_writer_if #(
  parameter int DATA_WIDTH = 32
);
  import matrix_op_defs_pkg::*;

  logic                                 write_request;
  logic                                 write_ready;
  logic [2:0]                           matrix_id;
  logic [7:0]                           actual_rows;
  logic [7:0]                           actual_cols;
  logic [0:MATRIX_NAME_BYTES-1][7:0]    matrix_name;
  logic [DATA_WIDTH-1:0]                data_in;
  logic                                 data_valid;
  logic                                 writer_ready;
  logic                                 write_done;
  logic                                 write_error;
  logic                                 busy;

  modport master (
    output write_request, matrix_id, actual_rows, actual_cols, matrix_name,
           data_in, data_valid,
    input  write_ready, writer_ready, write_done, write_error, busy
  );

  modport slave (
    input  write_request, matrix_id, actual_rows, actual_cols, matrix_name,
           data_in, data_valid,
    output write_ready, writer_ready, write_done, write_error, busy
  );

endinterface

// File: rtl/matrix_address_getter.sv
// Base word address of a matrix block: matrix_id * BLOCK_SIZE, wrapped to
// the BRAM address width.
module matrix_address_getter #(
  parameter int BLOCK_SIZE = 256,
  parameter int ADDR_WIDTH = 12
) (
  input  logic [2:0]            matrix_id,
  output logic [ADDR_WIDTH-1:0] base_addr
);

  assign base_addr = ADDR_WIDTH'(32'(matrix_id) * 32'(BLOCK_SIZE));

endmodule

// File: rtl/matrix_result_writer.sv
// Stores one operator result (metadata words, then row-major data) into its
// matrix BRAM block. Optional tail zeroing: MATRIX_WRITER_ZERO_FILL_EN.
module matrix_result_writer
  import matrix_op_defs_pkg::*;
#(
  parameter int BLOCK_SIZE = MATRIX_BLOCK_SIZE,
  parameter int ADDR_WIDTH = MATRIX_ADDR_WIDTH,
  parameter int DATA_WIDTH = MATRIX_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  matrix_result_writer_if.slave wr,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din
);

  localparam int META = MATRIX_METADATA_WORDS;
  localparam logic [ADDR_WIDTH-1:0] META_LAST = ADDR_WIDTH'(META - 1);
`ifdef MATRIX_WRITER_ZERO_FILL_EN
  localparam logic [ADDR_WIDTH-1:0] BLOCK_LAST = ADDR_WIDTH'(BLOCK_SIZE - 1);
`endif

  matrix_writer_state_e              state_reg;
  logic [2:0]                        id_reg;
  logic [7:0]                        rows_reg;
  logic [7:0]                        cols_reg;
  logic [0:MATRIX_NAME_BYTES-1][7:0] name_reg;
  logic [15:0]                       count_reg;
  logic [15:0]                       beat_idx_reg;
  logic [ADDR_WIDTH-1:0]             word_idx_reg;
  logic                              write_ready_reg;
  logic                              writer_ready_reg;
  logic                              write_done_reg;
  logic                              write_error_reg;
  logic                              busy_reg;

  logic [ADDR_WIDTH-1:0]             base_addr;
  logic [15:0]                       req_count;
  logic                              beat_accept;
  logic [31:0]                       name_lo;
  logic [31:0]                       name_hi;
  logic [DATA_WIDTH-1:0]             meta_word;

  matrix_address_getter #(
    .BLOCK_SIZE (BLOCK_SIZE),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_getter (
    .matrix_id (id_reg),
    .base_addr (base_addr)
  );

  assign req_count   = 16'(wr.actual_rows) * 16'(wr.actual_cols);
  assign beat_accept = (state_reg == WR_STREAM) && writer_ready_reg && wr.data_valid;

  // Name bytes packed little-endian: byte 0 lands in bits [7:0] of word 1.
  for (genvar gi = 0; gi < 4; gi++) begin : g_name_pack
    assign name_lo[gi*8 +: 8] = name_reg[gi];
    assign name_hi[gi*8 +: 8] = name_reg[gi+4];
  end

  always_comb begin
    meta_word = '0;
    if (word_idx_reg == ADDR_WIDTH'(0))
      meta_word = DATA_WIDTH'(encode_shape_word(rows_reg, cols_reg));
    else if (word_idx_reg == ADDR_WIDTH'(1))
      meta_word = DATA_WIDTH'(name_lo);
    else if (word_idx_reg == ADDR_WIDTH'(2))
      meta_word = DATA_WIDTH'(name_hi);
  end

  always_comb begin
    mem_we   = 1'b0;
    mem_din  = '0;
    mem_addr = base_addr + word_idx_reg;
    case (state_reg)
      WR_META: begin
        mem_we  = 1'b1;
        mem_din = meta_word;
      end
      WR_STREAM: begin
        // Oversized results are drained but never reach memory.
        mem_we  = beat_accept && !write_error_reg;
        mem_din = wr.data_in;
      end
      WR_FILL:  mem_we = 1'b1;
      default:  mem_we = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= WR_IDLE;
      id_reg           <= '0;
      rows_reg         <= '0;
      cols_reg         <= '0;
      name_reg         <= '0;
      count_reg        <= '0;
      beat_idx_reg     <= '0;
      word_idx_reg     <= '0;
      write_ready_reg  <= 1'b1;
      writer_ready_reg <= 1'b0;
      write_done_reg   <= 1'b0;
      write_error_reg  <= 1'b0;
      busy_reg         <= 1'b0;
    end else begin
      case (state_reg)
        WR_IDLE, WR_DONE: begin
          if (wr.write_request) begin
            id_reg          <= wr.matrix_id;
            rows_reg        <= wr.actual_rows;
            cols_reg        <= wr.actual_cols;
            name_reg        <= wr.matrix_name;
            count_reg       <= req_count;
            beat_idx_reg    <= '0;
            word_idx_reg    <= '0;
            write_done_reg  <= 1'b0;
            write_error_reg <= 1'b0;
            if (req_count == 16'd0) begin
              write_error_reg <= 1'b1;
              write_done_reg  <= 1'b1;
              state_reg       <= WR_DONE;
            end else if (!is_data_capacity_ok(req_count, BLOCK_SIZE, META)) begin
              write_error_reg  <= 1'b1;
              writer_ready_reg <= 1'b1;
              write_ready_reg  <= 1'b0;
              busy_reg         <= 1'b1;
              state_reg        <= WR_STREAM;
            end else begin
              write_ready_reg <= 1'b0;
              busy_reg        <= 1'b1;
              state_reg       <= WR_META;
            end
          end
        end
        WR_META: begin
          word_idx_reg <= word_idx_reg + 1'b1;
          if (word_idx_reg == META_LAST) begin
            writer_ready_reg <= 1'b1;
            state_reg        <= WR_STREAM;
          end
        end
        WR_STREAM: begin
          if (beat_accept) begin
            word_idx_reg <= word_idx_reg + 1'b1;
            beat_idx_reg <= beat_idx_reg + 16'd1;
            if (beat_idx_reg == count_reg - 16'd1) begin
              writer_ready_reg <= 1'b0;
`ifdef MATRIX_WRITER_ZERO_FILL_EN
              if (!write_error_reg && (word_idx_reg != BLOCK_LAST)) begin
                state_reg <= WR_FILL;
              end else begin
                write_done_reg  <= 1'b1;
                write_ready_reg <= 1'b1;
                busy_reg        <= 1'b0;
                state_reg       <= WR_DONE;
              end
`else
              write_done_reg  <= 1'b1;
              write_ready_reg <= 1'b1;
              busy_reg        <= 1'b0;
              state_reg       <= WR_DONE;
`endif
            end
          end
        end
`ifdef MATRIX_WRITER_ZERO_FILL_EN
        WR_FILL: begin
          word_idx_reg <= word_idx_reg + 1'b1;
          if (word_idx_reg == BLOCK_LAST) begin
            write_done_reg  <= 1'b1;
            write_ready_reg <= 1'b1;
            busy_reg        <= 1'b0;
            state_reg       <= WR_DONE;
          end
        end
`endif
        default: state_reg <= WR_IDLE;
      endcase
    end
  end

  assign wr.write_ready  = write_ready_reg;
  assign wr.writer_ready = writer_ready_reg;
  assign wr.write_done   = write_done_reg;
  assign wr.write_error  = write_error_reg;
  assign wr.busy         = busy_reg;

endmodule

// File: tb/tb_matrix_result_writer.sv
// Directed bench for matrix_result_writer: memory model fed from the BRAM
// write port, hand-computed block images, one line per transaction.
`timescale 1ns/1ps
module tb_matrix_result_writer;
  import matrix_op_defs_pkg::*;

  localparam int BS   = 16;
  localparam int AW   = 8;
  localparam int DW   = 32;
  localparam int META = MATRIX_METADATA_WORDS;
  localparam logic [31:0] SENT = 32'hA5A5_A5A5;
`ifdef MATRIX_WRITER_ZERO_FILL_EN
  localparam bit FILL_EN = 1'b1;
`else
  localparam bit FILL_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;

  logic [31:0] mem [0:255];
  int write_cnt = 0;
  int n_checks  = 0;
  int n_pass    = 0;

  matrix_result_writer_if #(.DATA_WIDTH(DW)) ifc();

  matrix_result_writer #(
    .BLOCK_SIZE (BS),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr       (ifc),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_din  (mem_din)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we === 1'b1) begin
      mem[mem_addr] = mem_din;
      write_cnt++;
    end
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [2:0] id, input logic [7:0] r, input logic [7:0] c,
                         input logic [63:0] name);
    ifc.matrix_id     = id;
    ifc.actual_rows   = r;
    ifc.actual_cols   = c;
    ifc.matrix_name   = name;
    ifc.write_request = 1'b1;
    tick();
    ifc.write_request = 1'b0;
  endtask

  task automatic send_beats(input int n, input int gap, input logic [31:0] first);
    for (int b = 0; b < n; b++) begin
      int waited = 0;
      ifc.data_in    = first + 32'(b);
      ifc.data_valid = 1'b1;
      while (!ifc.writer_ready && waited < 40) begin
        tick();
        waited++;
      end
      if (waited >= 40) begin
        check_value("beat_ready_timeout", 32'(waited), 32'd0);
        ifc.data_valid = 1'b0;
        return;
      end
      tick();
      ifc.data_valid = 1'b0;
      repeat (gap) tick();
    end
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (ifc.write_done !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
    check_value(tag, 32'(ifc.write_done), 32'd1);
  endtask

  task automatic check_block(input string tag, input int base, input int count,
                             input logic [31:0] shape, input logic [31:0] w1,
                             input logic [31:0] w2, input logic [31:0] first);
    check_value($sformatf("%s_meta0", tag), mem[base],     shape);
    check_value($sformatf("%s_meta1", tag), mem[base + 1], w1);
    check_value($sformatf("%s_meta2", tag), mem[base + 2], w2);
    for (int k = 0; k < count; k++)
      check_value($sformatf("%s_data%0d", tag, k), mem[base + META + k], first + 32'(k));
    for (int a = base + META + count; a < base + BS; a++)
      check_value($sformatf("%s_tail%0d", tag, a - base), mem[a], FILL_EN ? 32'd0 : SENT);
  endtask

  initial begin
    int cnt0;
    int lat;
    for (int a = 0; a < 256; a++) mem[a] = SENT;
    ifc.write_request = 1'b0;
    ifc.matrix_id     = '0;
    ifc.actual_rows   = '0;
    ifc.actual_cols   = '0;
    ifc.matrix_name   = '0;
    ifc.data_in       = '0;
    ifc.data_valid    = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_value("rst_write_ready",  32'(ifc.write_ready),  32'd1);
    check_value("rst_busy",         32'(ifc.busy),         32'd0);
    check_value("rst_writer_ready", 32'(ifc.writer_ready), 32'd0);
    check_value("rst_write_done",   32'(ifc.write_done),   32'd0);
    check_value("rst_write_error",  32'(ifc.write_error),  32'd0);
    check_value("rst_mem_we",       32'(mem_we),           32'd0);
    rst_n = 1'b1;
    tick();

    // 2x3 "ADDRES" into block 2; stray data_valid during META must be ignored.
    cnt0 = write_cnt;
    ifc.data_valid = 1'b1;
    ifc.data_in    = 32'hBAD0_0BAD;
    request(3'd2, 8'd2, 8'd3, {"ADDRES", 16'h0});
    check_value("t1_busy",        32'(ifc.busy),        32'd1);
    check_value("t1_write_ready", 32'(ifc.write_ready), 32'd0);
    check_value("t1_meta_we",     32'(mem_we),          32'd1);
    check_value("t1_meta_addr",   32'(mem_addr),        32'd32);
    check_value("t1_meta_din",    mem_din,              32'h0000_0203);
    lat = 1;
    while (!ifc.writer_ready && lat < 20) begin
      tick();
      lat++;
    end
    check_value("t1_ready_latency", 32'(lat), 32'(META + 1));
    send_beats(6, 0, 32'd1);
    check_value("t1_done_latency",  32'(ifc.write_done),   FILL_EN ? 32'd0 : 32'd1);
    check_value("t1_writer_ready",  32'(ifc.writer_ready), 32'd0);
    wait_done("t1_done");
    check_value("t1_error",  32'(ifc.write_error), 32'd0);
    check_value("t1_busy_end", 32'(ifc.busy),      32'd0);
    check_value("t1_writes", 32'(write_cnt - cnt0), FILL_EN ? 32'd16 : 32'd9);
    check_block("t1", 32, 6, 32'h0000_0203, 32'h5244_4441, 32'h0000_5345, 32'd1);
    $display("txn t1 id=2 2x3 ADDRES writes=%0d", write_cnt - cnt0);

    // Stalled stream into block 3, plus a request pulse while busy.
    cnt0 = write_cnt;
    request(3'd3, 8'd2, 8'd3, {"STALL", 24'h0});
    ifc.matrix_id     = 3'd7;
    ifc.actual_rows   = 8'd0;
    ifc.write_request = 1'b1;
    tick();
    ifc.write_request = 1'b0;
    send_beats(6, 3, 32'd1);
    wait_done("t2_done");
    check_value("t2_error",  32'(ifc.write_error), 32'd0);
    check_value("t2_writes", 32'(write_cnt - cnt0), FILL_EN ? 32'd16 : 32'd9);
    check_block("t2", 48, 6, 32'h0000_0203, 32'h4C41_5453, 32'h0000_004C, 32'd1);
    check_value("t2_block7_untouched", mem[112], SENT);
    $display("txn t2 id=3 2x3 STALL gap=3 writes=%0d", write_cnt - cnt0);

    // Empty shape.
    cnt0 = write_cnt;
    request(3'd1, 8'd0, 8'd5, {"EMPTY", 24'h0});
    check_value("t3_done",        32'(ifc.write_done),  32'd1);
    check_value("t3_error",       32'(ifc.write_error), 32'd1);
    check_value("t3_write_ready", 32'(ifc.write_ready), 32'd1);
    check_value("t3_busy",        32'(ifc.busy),        32'd0);
    tick();
    tick();
    check_value("t3_writes", 32'(write_cnt - cnt0), 32'd0);
    $display("txn t3 id=1 0x5 EMPTY writes=%0d", write_cnt - cnt0);

    // 4x4 = 16 beats exceeds 13-word capacity: drained, never written.
    cnt0 = write_cnt;
    request(3'd4, 8'd4, 8'd4, {"BIG", 40'h0});
    check_value("t4_done_cleared", 32'(ifc.write_done),  32'd0);
    check_value("t4_error",        32'(ifc.write_error), 32'd1);
    check_value("t4_busy",         32'(ifc.busy),        32'd1);
    send_beats(16, 0, 32'd100);
    wait_done("t4_done");
    check_value("t4_error_end", 32'(ifc.write_error), 32'd1);
    check_value("t4_writes",    32'(write_cnt - cnt0), 32'd0);
    check_value("t4_mem64",     mem[64], SENT);
    $display("txn t4 id=4 4x4 BIG writes=%0d", write_cnt - cnt0);

    // Reset after beat 2 of 6, then rerun the same block.
    request(3'd5, 8'd2, 8'd3, {"MUL", 40'h0});
    send_beats(2, 0, 32'd1);
    rst_n = 1'b0;
    #1;
    check_value("t5_write_ready",  32'(ifc.write_ready),  32'd1);
    check_value("t5_busy",         32'(ifc.busy),         32'd0);
    check_value("t5_writer_ready", 32'(ifc.writer_ready), 32'd0);
    check_value("t5_done",         32'(ifc.write_done),   32'd0);
    check_value("t5_error",        32'(ifc.write_error),  32'd0);
    check_value("t5_mem_we",       32'(mem_we),           32'd0);
    check_value("t5_partial_kept", mem[84], 32'd2);
    check_value("t5_not_reached",  mem[85], SENT);
    tick();
    rst_n = 1'b1;
    tick();
    cnt0 = write_cnt;
    request(3'd5, 8'd2, 8'd3, {"MUL", 40'h0});
    send_beats(6, 0, 32'd11);
    wait_done("t5_done_rerun");
    check_value("t5_writes", 32'(write_cnt - cnt0), FILL_EN ? 32'd16 : 32'd9);
    check_block("t5", 80, 6, 32'h0000_0203, 32'h004C_554D, 32'h0000_0000, 32'd11);
    $display("txn t5 id=5 2x3 MUL reset-abort+rerun writes=%0d", write_cnt - cnt0);

    // 1x1 into block 6: tail zeroed only with the fill option.
    cnt0 = write_cnt;
    request(3'd6, 8'd1, 8'd1, "ABCDEFGH");
    send_beats(1, 0, 32'h77);
    wait_done("t6_done");
    check_value("t6_writes", 32'(write_cnt - cnt0), FILL_EN ? 32'd16 : 32'd4);
    check_block("t6", 96, 1, 32'h0000_0101, 32'h4443_4241, 32'h4847_4645, 32'h77);
    $display("txn t6 id=6 1x1 ABCDEFGH writes=%0d", write_cnt - cnt0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
